// File: rtl/command_decoder_gen.sv
// Byte-stream command decoder: pulls header/payload bytes from a FIFO and turns them
// into vertex writes, triangle/block commands, output-enable updates and texture uploads.
module command_decoder_gen #(
  parameter int unsigned VBYTES = 5,
  parameter int unsigned TEX_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cmd_rddata,
  input  logic              cmd_empty,
  output logic              cmd_pull,
  input  logic              out_almost_full,
  input  logic              tex_busy,
  output logic [1:0]        v_sel,
  output logic [7:0]        v_data,
  output logic [2:0]        v_addr,
  output logic              v_we,
  output logic [7:0]        command,
  output logic [1:0]        va_sel,
  output logic [1:0]        vb_sel,
  output logic [1:0]        vc_sel,
  output logic              write,
  output logic [TEX_AW-1:0] tex_addr,
  output logic [7:0]        tex_data,
  output logic              tex_we,
  output logic              out_en,
  output logic              busy
);

  typedef enum logic [2:0] {StIdle, StVtx, StBlk, StTlenH, StTlenL, StTexData} state_e;

  localparam logic [2:0] VtxLast = 3'(VBYTES - 1);

  state_e            state_q, state_d;
  logic              did_pull_q, did_pull_d;
  logic [1:0]        v_sel_q, v_sel_d;
  logic              out_en_q, out_en_d;
  logic [TEX_AW-1:0] tex_addr_q, tex_addr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [15:0]       len_q, len_d;
  logic              consumed;

  assign cmd_pull = !cmd_empty && !out_almost_full && rst_n &&
                    !(state_q == StTexData && tex_busy);

  // Data-path outputs mirror the FIFO byte directly; only the strobes qualify them.
  assign v_data   = cmd_rddata;
  assign tex_data = cmd_rddata;
  assign va_sel   = cmd_rddata[5:4];
  assign vb_sel   = cmd_rddata[3:2];
  assign vc_sel   = cmd_rddata[1:0];
  assign v_sel    = v_sel_q;
  assign out_en   = out_en_q;
  assign tex_addr = tex_addr_q;
  assign busy     = (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    did_pull_d = cmd_pull;
    v_sel_d    = v_sel_q;
    out_en_d   = out_en_q;
    tex_addr_d = tex_addr_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    v_we       = 1'b0;
    v_addr     = 3'd0;
    write      = 1'b0;
    command    = 8'h00;
    tex_we     = 1'b0;
    // A byte pulled just before reset is dropped rather than decoded.
    consumed   = did_pull_q && rst_n;

    if (consumed) begin
      unique case (state_q)
        StIdle: begin
          if (cmd_rddata[7:6] == 2'b11) begin
            v_sel_d = cmd_rddata[5:4];
            cnt_d   = VtxLast;
            state_d = StVtx;
          end else if (cmd_rddata[7:6] == 2'b10) begin
            write = 1'b1;
          end else if (cmd_rddata[7:6] == 2'b01) begin
            state_d = StBlk;
          end else if (!cmd_rddata[5]) begin
            out_en_d = cmd_rddata[0];
          end else begin
            tex_addr_d = '0;
            state_d    = StTlenH;
          end
        end
        StVtx: begin
          v_we   = 1'b1;
          v_addr = cnt_q;
          if (cnt_q == 3'd0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        StBlk: begin
          command = {1'b1, cmd_rddata[6:0]};
          write   = 1'b1;
          state_d = StIdle;
        end
        StTlenH: begin
          len_d   = {cmd_rddata, len_q[7:0]};
          state_d = StTlenL;
        end
        StTlenL: begin
          len_d   = {len_q[15:8], cmd_rddata};
          state_d = ({len_q[15:8], cmd_rddata} == 16'd0) ? StIdle : StTexData;
        end
        StTexData: begin
          tex_we     = 1'b1;
          tex_addr_d = tex_addr_q + TEX_AW'(1);
          len_d      = len_q - 16'd1;
          if (len_q == 16'd1) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      did_pull_q <= 1'b0;
      v_sel_q    <= 2'd0;
      out_en_q   <= 1'b0;
      tex_addr_q <= '0;
      cnt_q      <= 3'd0;
      len_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      did_pull_q <= did_pull_d;
      v_sel_q    <= v_sel_d;
      out_en_q   <= out_en_d;
      tex_addr_q <= tex_addr_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
    end
  end

endmodule
